// File: rtl/rmt_match_router_if.sv
// AXI-Stream bundle shared by the ingress and egress sides of the router.
interface rmt_match_router_if #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int DEST_WIDTH = 2
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic                  tvalid;
  logic                  tready;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic [DEST_WIDTH-1:0] tdest;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, tdest, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, tdest, output tready);
endinterface

// File: rtl/rmt_match_router.sv
// Match-action router: classifies each frame on its first beat (EtherType,
// UDP delimiter, function type lookup) and either forwards it with a chosen
// tdest through a single output register, or swallows it.
module rmt_match_router #(
  parameter int              DATA_WIDTH   = 512,
  parameter int              KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int              USER_WIDTH   = 1,
  parameter int              DEST_WIDTH   = 2,
  parameter int              TABLE_DEPTH  = 4,
  parameter int              ETHER_OFFSET = 12,
  parameter int              DELIM_OFFSET = 42,
  parameter int              FUNC_OFFSET  = 44,
  parameter logic [15:0]     ETHER_VALUE  = 16'h0008,
  parameter logic [15:0]     DELIM_VALUE  = 16'hE1F0,
  parameter int              DEFAULT_DEST = 0,
  parameter int              CNT_WIDTH    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  rmt_match_router_if.slave              s_axis,
  rmt_match_router_if.master             m_axis,
  input  logic                           cfg_wr_en,
  input  logic [$clog2(TABLE_DEPTH)-1:0] cfg_wr_addr,
  input  logic [15:0]                    cfg_wr_func,
  input  logic [DEST_WIDTH-1:0]          cfg_wr_dest,
  input  logic                           cfg_wr_valid,
  input  logic                           cfg_drop_miss,
  input  logic                           stat_clear,
  output logic [CNT_WIDTH-1:0]           stat_pass_count,
  output logic [CNT_WIDTH-1:0]           stat_drop_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, DROP = 2'd2} state_t;

  state_t                  state_q, state_d;
  logic [15:0]             tbl_func_q [TABLE_DEPTH];
  logic [15:0]             tbl_func_d [TABLE_DEPTH];
  logic [DEST_WIDTH-1:0]   tbl_dest_q [TABLE_DEPTH];
  logic [DEST_WIDTH-1:0]   tbl_dest_d [TABLE_DEPTH];
  logic [TABLE_DEPTH-1:0]  tbl_vld_q, tbl_vld_d;

  logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
  logic [KEEP_WIDTH-1:0]   m_tkeep_q, m_tkeep_d;
  logic                    m_tvalid_q, m_tvalid_d;
  logic                    m_tlast_q, m_tlast_d;
  logic [USER_WIDTH-1:0]   m_tuser_q, m_tuser_d;
  logic [DEST_WIDTH-1:0]   m_tdest_q, m_tdest_d;

  logic [CNT_WIDTH-1:0]    pass_cnt_q, pass_cnt_d;
  logic [CNT_WIDTH-1:0]    drop_cnt_q, drop_cnt_d;

  logic                    s_ready, s_hs;
  logic [15:0]             ether_f, delim_f, func_f;
  logic                    hdr_ok, frame_match, hit, fwd;
  logic [DEST_WIDTH-1:0]   hit_dest, sel_dest, load_dest;
  logic                    load, pass_inc, drop_inc;

  // Ingress accepts when the output slot frees up, or unconditionally while draining a dropped frame.
  assign s_ready = !rst && (state_q == DROP || !m_tvalid_q || m_axis.tready);
  assign s_hs    = s_axis.tvalid && s_ready;

  assign ether_f     = s_axis.tdata[8*ETHER_OFFSET +: 16];
  assign delim_f     = s_axis.tdata[8*DELIM_OFFSET +: 16];
  assign func_f      = s_axis.tdata[8*FUNC_OFFSET +: 16];
  assign hdr_ok      = &s_axis.tkeep[FUNC_OFFSET+1:0];
  assign frame_match = hdr_ok && (ether_f == ETHER_VALUE) && (delim_f == DELIM_VALUE);

  // Priority lookup on the registered table; scanning downward leaves the lowest matching index in place.
  always_comb begin
    hit      = 1'b0;
    hit_dest = '0;
    for (int i = TABLE_DEPTH - 1; i >= 0; i--) begin
      if (tbl_vld_q[i] && tbl_func_q[i] == func_f) begin
        hit      = 1'b1;
        hit_dest = tbl_dest_q[i];
      end
    end
  end

  assign fwd      = frame_match && (hit || !cfg_drop_miss);
  assign sel_dest = hit ? hit_dest : DEST_WIDTH'(DEFAULT_DEST);

  // Frame FSM: beat-0 decision in IDLE, then forward or swallow until tlast.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    load_dest = m_tdest_q;
    pass_inc  = 1'b0;
    drop_inc  = 1'b0;
    case (state_q)
      IDLE: if (s_hs) begin
        if (fwd) begin
          load      = 1'b1;
          load_dest = sel_dest;
          pass_inc  = 1'b1;
          if (!s_axis.tlast) state_d = PASS;
        end else begin
          drop_inc = 1'b1;
          if (!s_axis.tlast) state_d = DROP;
        end
      end
      PASS: if (s_hs) begin
        load = 1'b1;
        if (s_axis.tlast) state_d = IDLE;
      end
      DROP: if (s_hs && s_axis.tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output register: load on a forwarded beat, otherwise retire the held beat once taken.
  always_comb begin
    m_tdata_d  = m_tdata_q;
    m_tkeep_d  = m_tkeep_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tuser_d  = m_tuser_q;
    m_tdest_d  = m_tdest_q;
    if (load) begin
      m_tdata_d  = s_axis.tdata;
      m_tkeep_d  = s_axis.tkeep;
      m_tvalid_d = 1'b1;
      m_tlast_d  = s_axis.tlast;
      m_tuser_d  = s_axis.tuser;
      m_tdest_d  = load_dest;
    end else if (m_axis.tready) begin
      m_tvalid_d = 1'b0;
    end
  end

  // Saturating statistics; a clear overrides any increment in the same cycle.
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (pass_inc && pass_cnt_q != '1) pass_cnt_d = pass_cnt_q + CNT_WIDTH'(1);
    if (drop_inc && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    if (stat_clear) begin
      pass_cnt_d = '0;
      drop_cnt_d = '0;
    end
  end

  // Table write port; lookups this cycle still see the old contents.
  always_comb begin
    tbl_func_d = tbl_func_q;
    tbl_dest_d = tbl_dest_q;
    tbl_vld_d  = tbl_vld_q;
    if (cfg_wr_en) begin
      tbl_func_d[cfg_wr_addr] = cfg_wr_func;
      tbl_dest_d[cfg_wr_addr] = cfg_wr_dest;
      tbl_vld_d[cfg_wr_addr]  = cfg_wr_valid;
    end
  end

  // State, table, output and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tbl_vld_q  <= '0;
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        tbl_func_q[i] <= '0;
        tbl_dest_q[i] <= '0;
      end
      m_tdata_q  <= '0;
      m_tkeep_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= '0;
      m_tdest_q  <= '0;
      pass_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      tbl_func_q <= tbl_func_d;
      tbl_dest_q <= tbl_dest_d;
      tbl_vld_q  <= tbl_vld_d;
      m_tdata_q  <= m_tdata_d;
      m_tkeep_q  <= m_tkeep_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tuser_q  <= m_tuser_d;
      m_tdest_q  <= m_tdest_d;
      pass_cnt_q <= pass_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign s_axis.tready   = s_ready;
  assign m_axis.tdata    = m_tdata_q;
  assign m_axis.tkeep    = m_tkeep_q;
  assign m_axis.tvalid   = m_tvalid_q;
  assign m_axis.tlast    = m_tlast_q;
  assign m_axis.tuser    = m_tuser_q;
  assign m_axis.tdest    = m_tdest_q;
  assign stat_pass_count = pass_cnt_q;
  assign stat_drop_count = drop_cnt_q;

endmodule

// File: tb/tb_rmt_match_router.sv
// Bench for rmt_match_router: frame-level reference model feeds an expected-beat
// queue; an independent monitor compares every egress handshake against it.
module tb_rmt_match_router;
  localparam int DW = 512;
  localparam int KW = 64;
  localparam int UW = 1;
  localparam int TW = 2;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rmt_match_router_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .DEST_WIDTH(TW)) s_if ();
  rmt_match_router_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW), .DEST_WIDTH(TW)) m_if ();

  logic          cfg_wr_en = 0, cfg_wr_valid = 0, cfg_drop_miss = 0, stat_clear = 0;
  logic [1:0]    cfg_wr_addr = 0;
  logic [15:0]   cfg_wr_func = 0;
  logic [TW-1:0] cfg_wr_dest = 0;
  logic [31:0]   stat_pass_count, stat_drop_count;

  rmt_match_router dut (
    .clk(clk), .rst(rst), .s_axis(s_if), .m_axis(m_if),
    .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr), .cfg_wr_func(cfg_wr_func),
    .cfg_wr_dest(cfg_wr_dest), .cfg_wr_valid(cfg_wr_valid), .cfg_drop_miss(cfg_drop_miss),
    .stat_clear(stat_clear), .stat_pass_count(stat_pass_count), .stat_drop_count(stat_drop_count)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
    logic [TW-1:0] t;
  } beat_t;

  beat_t       exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          bp_mode = 0;     // 0 always ready, 1 random, 2 stalled
  logic [15:0] mf[TD];
  logic [1:0]  md[TD];
  bit          mv[TD];
  int unsigned mpass = 0, mdrop = 0;

  task automatic check(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference classification of a frame from its first beat.
  function automatic void decide(input logic [DW-1:0] d, input logic [KW-1:0] k, input bit drop_miss,
                                 output bit fwd, output logic [1:0] dest);
    bit hdr = 1;
    fwd = 0;
    dest = 0;
    for (int i = 0; i < 46; i++) if (!k[i]) hdr = 0;
    if (!(hdr && d[96 +: 16] == 16'h0008 && d[336 +: 16] == 16'hE1F0)) return;
    for (int i = 0; i < TD; i++) begin
      if (mv[i] && mf[i] == d[352 +: 16]) begin
        fwd = 1;
        dest = md[i];
        return;
      end
    end
    if (!drop_miss) fwd = 1;
  endfunction

  initial begin
    m_if.tready = 0;
    forever begin
      @(posedge clk); #1;
      case (bp_mode)
        0:       m_if.tready = 1;
        1:       m_if.tready = ($urandom_range(0, 3) != 0);
        default: m_if.tready = 0;
      endcase
    end
  end

  // Monitor: every egress handshake must match the head of the expected queue.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat got tdata=%0h exp=none", m_if.tdata);
        end else begin
          e = exp_q.pop_front();
          check("tdata", m_if.tdata, e.d);
          check("tkeep", m_if.tkeep, e.k);
          check("tlast", m_if.tlast, e.l);
          check("tuser", m_if.tuser, e.u);
          check("tdest", m_if.tdest, e.t);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input int a, input logic [15:0] f, input logic [1:0] dst, input bit v);
    cfg_wr_en = 1; cfg_wr_addr = a[1:0]; cfg_wr_func = f; cfg_wr_dest = dst; cfg_wr_valid = v;
    cycle();
    cfg_wr_en = 0;
    mf[a] = f; md[a] = dst; mv[a] = v;
  endtask

  task automatic build(input int nb, input logic [15:0] eth, input logic [15:0] dl, input logic [15:0] fn,
                       input bit short_h, output beat_t bs[$]);
    logic [KW-1:0] full;
    full = '1;
    bs = {};
    for (int i = 0; i < nb; i++) begin
      beat_t b;
      for (int j = 0; j < DW / 32; j++) b.d[32*j +: 32] = $urandom();
      b.k = (i == 0) ? full : {$urandom(), $urandom()} | 64'h1;
      b.l = (i == nb - 1);
      b.u = UW'($urandom_range(0, 1));
      b.t = '0;
      if (i == 0) begin
        b.d[96 +: 16]  = eth;
        b.d[336 +: 16] = dl;
        b.d[352 +: 16] = fn;
        if (short_h) b.k = full >> (KW - 41);
      end
      bs.push_back(b);
    end
  endtask

  task automatic drive_beat(input beat_t b, input bit need_ready);
    int n = 0;
    bit first = 1;
    s_if.tvalid = 1; s_if.tdata = b.d; s_if.tkeep = b.k; s_if.tlast = b.l; s_if.tuser = b.u;
    forever begin
      @(negedge clk);
      if (first && need_ready) check("drop_tready", s_if.tready, 1);
      first = 0;
      if (s_if.tready) break;
      if (++n > 300) begin
        $display("FAIL ingress_timeout got=stuck exp=tready");
        $fatal(1, "ingress stuck");
      end
    end
    cycle();
    s_if.tvalid = 0;
  endtask

  task automatic send_beats(input beat_t bs[$], input bit gaps);
    bit fwd;
    logic [1:0] dst;
    decide(bs[0].d, bs[0].k, cfg_drop_miss, fwd, dst);
    if (fwd) begin
      mpass++;
      foreach (bs[i]) begin
        beat_t e = bs[i];
        e.t = dst;
        exp_q.push_back(e);
      end
    end else mdrop++;
    foreach (bs[i]) begin
      if (gaps) repeat ($urandom_range(0, 2)) cycle();
      drive_beat(bs[i], !fwd && i > 0);
    end
  endtask

  task automatic frame(input int nb, input logic [15:0] eth, input logic [15:0] dl, input logic [15:0] fn,
                       input bit short_h, input bit gaps);
    beat_t bs[$];
    build(nb, eth, dl, fn, short_h, bs);
    send_beats(bs, gaps);
  endtask

  task automatic drain_and_count();
    for (int n = 0; n < 500 && exp_q.size() != 0; n++) cycle();
    check("drain", exp_q.size(), 0);
    check("pass_count", stat_pass_count, mpass);
    check("drop_count", stat_drop_count, mdrop);
  endtask

  initial begin
    beat_t bs[$];
    logic [DW-1:0] d0;
    s_if.tvalid = 0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tlast = 0; s_if.tuser = '0; s_if.tdest = '0;
    for (int i = 0; i < TD; i++) begin mf[i] = 0; md[i] = 0; mv[i] = 0; end
    repeat (3) cycle();
    check("rst_tvalid", m_if.tvalid, 0);
    check("rst_tdata", m_if.tdata, 0);
    check("rst_tdest", m_if.tdest, 0);
    check("rst_tready", s_if.tready, 0);
    check("rst_pass", stat_pass_count, 0);
    rst = 0;
    cycle();

    // Directed: match, delimiter miss, default-dest miss, drop miss, priority.
    cfg_write(0, 16'h0100, 2'd1, 1);
    frame(3, 16'h0008, 16'hE1F0, 16'h0100, 0, 0);
    drain_and_count();
    frame(3, 16'h0008, 16'hFFFF, 16'h0100, 0, 0);
    frame(3, 16'h0008, 16'hE1F0, 16'h0100, 0, 0);
    drain_and_count();
    cfg_drop_miss = 0;
    frame(2, 16'h0008, 16'hE1F0, 16'h0200, 0, 0);
    cfg_drop_miss = 1;
    frame(2, 16'h0008, 16'hE1F0, 16'h0200, 0, 0);
    cfg_write(1, 16'h0300, 2'd2, 1);
    cfg_write(2, 16'h0300, 2'd3, 1);
    frame(2, 16'h0008, 16'hE1F0, 16'h0300, 0, 0);
    frame(2, 16'h0008, 16'hE1F0, 16'h0100, 1, 0);  // short first beat
    drain_and_count();

    // Backpressure mid-frame, then a single-beat frame.
    fork
      frame(4, 16'h0008, 16'hE1F0, 16'h0300, 0, 0);
      begin
        for (int n = 0; n < 50; n++) begin
          @(negedge clk);
          if (m_if.tvalid) break;
        end
        bp_mode = 2;
        @(negedge clk);
        check("stall_valid", m_if.tvalid, 1);
        d0 = m_if.tdata;
        repeat (5) begin
          @(negedge clk);
          check("stall_tdata", m_if.tdata, d0);
          check("stall_tready", s_if.tready, 0);
        end
        bp_mode = 0;
      end
    join
    frame(1, 16'h0008, 16'hE1F0, 16'h0100, 0, 0);
    frame(2, 16'h0008, 16'hE1F0, 16'h0300, 0, 0);
    drain_and_count();

    // Reset in the middle of a 4-beat frame.
    build(4, 16'h0008, 16'hE1F0, 16'h0100, 0, bs);
    exp_q.push_back('{d: bs[0].d, k: bs[0].k, l: bs[0].l, u: bs[0].u, t: 2'd1});
    drive_beat(bs[0], 0);
    drive_beat(bs[1], 0);
    s_if.tvalid = 1; s_if.tdata = bs[2].d; s_if.tkeep = bs[2].k; s_if.tlast = 0;
    rst = 1;
    #1;
    check("midrst_tvalid", m_if.tvalid, 0);
    check("midrst_tready", s_if.tready, 0);
    check("midrst_pass", stat_pass_count, 0);
    s_if.tvalid = 0;
    mpass = 0; mdrop = 0;
    for (int i = 0; i < TD; i++) mv[i] = 0;
    cycle();
    rst = 0;
    cycle();
    check("midrst_drain", exp_q.size(), 0);
    bs.delete(0); bs.delete(0); bs.delete(0);
    send_beats(bs, 0);  // leftover tail parsed as a fresh frame
    drain_and_count();

    // Counter clear colliding with an increment.
    cfg_write(0, 16'h0100, 2'd1, 1);
    build(1, 16'h0008, 16'hE1F0, 16'h0100, 0, bs);
    stat_clear = 1;
    send_beats(bs, 0);
    stat_clear = 0;
    mpass = 0; mdrop = 0;
    drain_and_count();

    // Randomized traffic with backpressure, gaps and table updates.
    cfg_write(1, 16'h0300, 2'd2, 1);
    cfg_write(2, 16'h0300, 2'd3, 1);
    bp_mode = 1;
    for (int f = 0; f < 40; f++) begin
      logic [15:0] fn, eth, dl;
      case ($urandom_range(0, 3))
        0: fn = 16'h0100;
        1: fn = 16'h0200;
        2: fn = 16'h0300;
        default: fn = 16'($urandom());
      endcase
      eth = ($urandom_range(0, 9) != 0) ? 16'h0008 : 16'($urandom());
      dl  = ($urandom_range(0, 7) != 0) ? 16'hE1F0 : 16'($urandom());
      cfg_drop_miss = $urandom_range(0, 1);
      if ($urandom_range(0, 5) == 0)
        cfg_write($urandom_range(0, 3), ($urandom_range(0, 1) != 0) ? 16'h0200 : 16'h0100,
                  2'($urandom_range(0, 3)), $urandom_range(0, 1));
      frame($urandom_range(1, 4), eth, dl, fn, $urandom_range(0, 9) == 0, 1);
    end
    bp_mode = 0;
    drain_and_count();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
